// File: rtl/wshb_arbiter.sv
// wshb_arbiter: round-robin two-requester Wishbone arbiter with burst-limited preemption
module wshb_arbiter #(
    parameter int MAX_BURST = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wshb_ifs_0_adr,
    input  logic [31:0] wshb_ifs_0_dat_ms,
    output logic [31:0] wshb_ifs_0_dat_sm,
    input  logic [3:0]  wshb_ifs_0_sel,
    input  logic [2:0]  wshb_ifs_0_cti,
    input  logic [1:0]  wshb_ifs_0_bte,
    input  logic        wshb_ifs_0_we,
    input  logic        wshb_ifs_0_stb,
    input  logic        wshb_ifs_0_cyc,
    output logic        wshb_ifs_0_ack,
    output logic        wshb_ifs_0_err,
    output logic        wshb_ifs_0_rty,
    input  logic [31:0] wshb_ifs_1_adr,
    input  logic [31:0] wshb_ifs_1_dat_ms,
    output logic [31:0] wshb_ifs_1_dat_sm,
    input  logic [3:0]  wshb_ifs_1_sel,
    input  logic [2:0]  wshb_ifs_1_cti,
    input  logic [1:0]  wshb_ifs_1_bte,
    input  logic        wshb_ifs_1_we,
    input  logic        wshb_ifs_1_stb,
    input  logic        wshb_ifs_1_cyc,
    output logic        wshb_ifs_1_ack,
    output logic        wshb_ifs_1_err,
    output logic        wshb_ifs_1_rty,
    output logic [31:0] wshb_ifm_adr,
    output logic [31:0] wshb_ifm_dat_ms,
    input  logic [31:0] wshb_ifm_dat_sm,
    output logic [3:0]  wshb_ifm_sel,
    output logic [2:0]  wshb_ifm_cti,
    output logic [1:0]  wshb_ifm_bte,
    output logic        wshb_ifm_we,
    output logic        wshb_ifm_stb,
    output logic        wshb_ifm_cyc,
    input  logic        wshb_ifm_ack,
    input  logic        wshb_ifm_err,
    input  logic        wshb_ifm_rty
);
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t        state;
    logic          last;
    logic [CW-1:0] cnt;
    logic [CW:0]   cnt_inc;
    logic          g0, g1, xfer, own_cyc, oth_cyc, wrap;
    assign g0      = state == GNT0;
    assign g1      = state == GNT1;
    assign xfer    = (g0 | g1) & (wshb_ifm_ack | wshb_ifm_err);
    assign own_cyc = g0 ? wshb_ifs_0_cyc : wshb_ifs_1_cyc;
    assign oth_cyc = g0 ? wshb_ifs_1_cyc : wshb_ifs_0_cyc;
    assign cnt_inc = {1'b0, cnt} + (CW+1)'(1);
    assign wrap    = cnt_inc == (CW+1)'(MAX_BURST);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wshb_ifs_0_cyc && (!wshb_ifs_1_cyc || last)) begin
                        state <= GNT0;
                        last  <= 1'b0;
                        cnt   <= '0;
                    end else if (wshb_ifs_1_cyc) begin
                        state <= GNT1;
                        last  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                GNT0, GNT1: begin
                    // Preempt only on a completed transfer so no cycle is left outstanding
                    if (!own_cyc || (xfer && wrap && oth_cyc))
                        state <= IDLE;
                    else if (xfer)
                        cnt <= wrap ? '0 : cnt_inc[CW-1:0];
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign wshb_ifm_adr    = g0 ? wshb_ifs_0_adr    : g1 ? wshb_ifs_1_adr    : '0;
    assign wshb_ifm_dat_ms = g0 ? wshb_ifs_0_dat_ms : g1 ? wshb_ifs_1_dat_ms : '0;
    assign wshb_ifm_sel    = g0 ? wshb_ifs_0_sel    : g1 ? wshb_ifs_1_sel    : '0;
    assign wshb_ifm_cti    = g0 ? wshb_ifs_0_cti    : g1 ? wshb_ifs_1_cti    : '0;
    assign wshb_ifm_bte    = g0 ? wshb_ifs_0_bte    : g1 ? wshb_ifs_1_bte    : '0;
    assign wshb_ifm_we     = g0 ? wshb_ifs_0_we     : g1 & wshb_ifs_1_we;
    assign wshb_ifm_stb    = g0 ? wshb_ifs_0_stb    : g1 & wshb_ifs_1_stb;
    assign wshb_ifm_cyc    = g0 ? wshb_ifs_0_cyc    : g1 & wshb_ifs_1_cyc;
    assign wshb_ifs_0_ack  = g0 & wshb_ifm_ack;
    assign wshb_ifs_0_err  = g0 & wshb_ifm_err;
    assign wshb_ifs_0_rty  = g0 & wshb_ifm_rty;
    assign wshb_ifs_1_ack  = g1 & wshb_ifm_ack;
    assign wshb_ifs_1_err  = g1 & wshb_ifm_err;
    assign wshb_ifs_1_rty  = g1 & wshb_ifm_rty;
    assign wshb_ifs_0_dat_sm = wshb_ifm_dat_sm;
    assign wshb_ifs_1_dat_sm = wshb_ifm_dat_sm;
endmodule

// File: tb/tb_wshb_arbiter.sv
// tb_wshb_arbiter: directed checks of grant sequencing, routing, preemption and reset
module tb_wshb_arbiter;
    logic        clk, rst;
    logic [31:0] s0_adr, s0_dat_ms, s0_dat_sm, s1_adr, s1_dat_ms, s1_dat_sm;
    logic [3:0]  s0_sel, s1_sel, m_sel;
    logic [2:0]  s0_cti, s1_cti, m_cti;
    logic [1:0]  s0_bte, s1_bte, m_bte;
    logic        s0_we, s0_stb, s0_cyc, s0_ack, s0_err, s0_rty;
    logic        s1_we, s1_stb, s1_cyc, s1_ack, s1_err, s1_rty;
    logic [31:0] m_adr, m_dat_ms, m_dat_sm;
    logic        m_we, m_stb, m_cyc, m_ack, m_err, m_rty;
    logic        ack_en, err_en, rty_en;
    int          n_pass = 0, n_total = 0;
    int          exp_a[14] = '{1, 1, 1, 1, 2, 0, 0, 0, 0, 2, 1, 1, 1, 1};
    int          exp_b[5]  = '{0, 0, 0, 2, 1};
    bit          found;

    wshb_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .wshb_ifs_0_adr(s0_adr), .wshb_ifs_0_dat_ms(s0_dat_ms), .wshb_ifs_0_dat_sm(s0_dat_sm),
        .wshb_ifs_0_sel(s0_sel), .wshb_ifs_0_cti(s0_cti), .wshb_ifs_0_bte(s0_bte),
        .wshb_ifs_0_we(s0_we), .wshb_ifs_0_stb(s0_stb), .wshb_ifs_0_cyc(s0_cyc),
        .wshb_ifs_0_ack(s0_ack), .wshb_ifs_0_err(s0_err), .wshb_ifs_0_rty(s0_rty),
        .wshb_ifs_1_adr(s1_adr), .wshb_ifs_1_dat_ms(s1_dat_ms), .wshb_ifs_1_dat_sm(s1_dat_sm),
        .wshb_ifs_1_sel(s1_sel), .wshb_ifs_1_cti(s1_cti), .wshb_ifs_1_bte(s1_bte),
        .wshb_ifs_1_we(s1_we), .wshb_ifs_1_stb(s1_stb), .wshb_ifs_1_cyc(s1_cyc),
        .wshb_ifs_1_ack(s1_ack), .wshb_ifs_1_err(s1_err), .wshb_ifs_1_rty(s1_rty),
        .wshb_ifm_adr(m_adr), .wshb_ifm_dat_ms(m_dat_ms), .wshb_ifm_dat_sm(m_dat_sm),
        .wshb_ifm_sel(m_sel), .wshb_ifm_cti(m_cti), .wshb_ifm_bte(m_bte),
        .wshb_ifm_we(m_we), .wshb_ifm_stb(m_stb), .wshb_ifm_cyc(m_cyc),
        .wshb_ifm_ack(m_ack), .wshb_ifm_err(m_err), .wshb_ifm_rty(m_rty)
    );

    // Slave that answers every strobed cycle with whichever response is enabled
    assign m_ack    = m_cyc & m_stb & ack_en;
    assign m_err    = m_cyc & m_stb & err_en;
    assign m_rty    = m_cyc & m_stb & rty_en;
    assign m_dat_sm = 32'hD00D_BEEF;

    always #5 clk = ~clk;

    function automatic int gnt();
        return m_adr == 32'hA0 ? 0 : m_adr == 32'hB1 ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_nox(input string tag);
        chk(tag, 32'($isunknown({m_adr, m_dat_ms, m_sel, m_cti, m_bte, m_we, m_stb, m_cyc,
                                  s0_ack, s0_err, s0_rty, s1_ack, s1_err, s1_rty})), 0);
    endtask

    initial begin
        clk = 0; rst = 1;
        s0_adr = 32'hA0; s0_dat_ms = 32'h1111_0000; s0_sel = 4'h3; s0_cti = 3'd2; s0_bte = 2'd1;
        s1_adr = 32'hB1; s1_dat_ms = 32'h2222_0000; s1_sel = 4'hC; s1_cti = 3'd0; s1_bte = 2'd0;
        s0_we = 1; s1_we = 0; s0_stb = 1; s1_stb = 1; s0_cyc = 1; s1_cyc = 1;
        ack_en = 1; err_en = 0; rty_en = 0;
        #1;
        chk("rst_cyc", m_cyc, 0);
        chk("rst_stb", m_stb, 0);
        chk("rst_we", m_we, 0);
        chk("rst_ack0", s0_ack, 0);
        chk("rst_ack1", s1_ack, 0);
        chk_nox("rst_nox");
        tick();
        tick();
        chk("rst_hold_cyc", m_cyc, 0);
        // Only requester 0: one idle cycle, then a held grant across burst wraps
        s1_cyc = 0;
        rst = 0;
        chk("rel_idle", gnt(), 2);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("solo_gnt", gnt(), 0);
            chk("solo_ack0", s0_ack, 1);
            chk("solo_ack1", s1_ack, 0);
        end
        chk("pass_we", m_we, 1);
        chk("pass_sel", m_sel, 4'h3);
        chk("pass_dat", m_dat_ms, 32'h1111_0000);
        chk("pass_cti", m_cti, 3'd2);
        chk("pass_bte", m_bte, 2'd1);
        chk("bcast0", s0_dat_sm, 32'hD00D_BEEF);
        chk("bcast1", s1_dat_sm, 32'hD00D_BEEF);
        s0_cyc = 0;
        tick();
        chk("drop_idle", gnt(), 2);
        chk("idle_bcast1", s1_dat_sm, 32'hD00D_BEEF);
        // Both requesting: round-robin alternation of 4-ack bursts with turnarounds
        s0_cyc = 1; s1_cyc = 1;
        foreach (exp_a[i]) begin
            tick();
            chk($sformatf("rr_gnt%0d", i), gnt(), exp_a[i]);
            chk("rr_ack0", s0_ack, exp_a[i] == 0);
            chk("rr_ack1", s1_ack, exp_a[i] == 1);
        end
        // Burst limit reached with requester 0 absent: grant stays with 1
        s0_cyc = 0;
        tick();
        chk("wrap_held_a", gnt(), 1);
        tick();
        chk("wrap_held_b", gnt(), 1);
        tick();
        chk("wrap_held_c", gnt(), 1);
        s1_cyc = 0; s0_cyc = 1;
        #1;
        chk("swap_cyc", m_cyc, 0);
        chk("swap_ack0", s0_ack, 0);
        tick();
        chk("swap_idle", gnt(), 2);
        tick();
        chk("swap_gnt0", gnt(), 0);
        s1_cyc = 1;
        foreach (exp_b[i]) begin
            tick();
            chk($sformatf("cnt_clr%0d", i), gnt(), exp_b[i]);
        end
        // Retries neither count toward the burst nor release the bus
        ack_en = 0; rty_en = 1;
        #1;
        chk("rty_route1", s1_rty, 1);
        chk("rty_route0", s0_rty, 0);
        chk("rty_noack", s1_ack, 0);
        tick();
        chk("rty_gnt1", gnt(), 1);
        tick();
        chk("rty_gnt2", gnt(), 1);
        tick();
        chk("rty_gnt3", gnt(), 1);
        ack_en = 1; rty_en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rty_acks", gnt(), 1);
        end
        tick();
        chk("rty_release", gnt(), 2);
        tick();
        chk("rty_next", gnt(), 0);
        err_en = 1;
        #1;
        chk("err_route0", s0_err, 1);
        chk("err_route1", s1_err, 0);
        err_en = 0;
        // Asynchronous reset in the middle of a GNT1 cycle
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = gnt() == 1;
        end
        chk("wait_gnt1", 32'(found), 1);
        s1_we = 1;
        #3 rst = 1;
        #1;
        chk("arst_cyc", m_cyc, 0);
        chk("arst_ack1", s1_ack, 0);
        chk("arst_we", m_we, 0);
        chk("arst_idle", gnt(), 2);
        chk_nox("arst_nox");
        tick();
        chk("arst_hold", m_cyc, 0);
        rst = 0;
        chk("post_idle", gnt(), 2);
        tick();
        chk("post_gnt0", gnt(), 0);
        chk_nox("post_nox");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
